// File: rtl/avalon_mm_pkg.sv
// Shared types and constants for the two-host Avalon-MM arbiter.
package avalon_mm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        WAIT_RD = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/avl_rr_grant2.sv
// Two-way round-robin chooser; on a tie the host not served last wins.
module avl_rr_grant2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (&req) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Shares one Avalon-MM slave between two hosts, one transaction at a time,
// with a saturating read-wait timeout.
module avalon_mm_arbiter
    import avalon_mm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [31:0]           m0_writedata,
    input  logic [3:0]            m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [31:0]           m0_readdata,
    output logic                  m0_readdatavalid,
    output logic [1:0]            m0_response,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [31:0]           m1_writedata,
    input  logic [3:0]            m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [31:0]           m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [1:0]            m1_response,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic                  s_read,
    output logic                  s_write,
    output logic [31:0]           s_writedata,
    output logic [3:0]            s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [31:0]           s_readdata,
    input  logic                  s_readdatavalid,
    input  logic [1:0]            s_response,
    output logic                  sts_timeout
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_e  state_q, state_d, st;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;

    logic [1:0]  req;
    logic [1:0]  grant;
    logic        sel1;
    logic        h_req;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    avl_rr_grant2 u_rr (
        .req        (req),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        // While in reset the outputs behave as in IDLE.
        st       = rst_n ? state_q : IDLE;
        sel1     = (st == GRANT1);
        h_req    = sel1 ? req[1] : req[0];
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        owner_d  = owner_q;
        s_addr       = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;
        s_byteenable = '0;
        m0_waitrequest = req[0];
        m1_waitrequest = req[1];
        rd_valid    = 1'b0;
        rd_data     = '0;
        rd_resp     = RESP_OKAY;
        sts_timeout = 1'b0;
        unique case (st)
            IDLE: begin
                if (grant[0]) begin
                    state_d = GRANT0;
                end else if (grant[1]) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                s_addr       = sel1 ? m1_addr : m0_addr;
                s_read       = sel1 ? m1_read : m0_read;
                // A simultaneous read and write forwards only the read.
                s_write      = sel1 ? (m1_write & ~m1_read)
                                    : (m0_write & ~m0_read);
                s_writedata  = sel1 ? m1_writedata : m0_writedata;
                s_byteenable = sel1 ? m1_byteenable : m0_byteenable;
                if (sel1) begin
                    m1_waitrequest = req[1] & s_waitrequest;
                end else begin
                    m0_waitrequest = req[0] & s_waitrequest;
                end
                if (!h_req) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    if (s_read) begin
                        state_d = WAIT_RD;
                        owner_d = sel1;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        last_d  = sel1;
                    end
                end
            end
            WAIT_RD: begin
                if (s_readdatavalid) begin
                    rd_valid = 1'b1;
                    rd_data  = s_readdata;
                    rd_resp  = s_response;
                    state_d  = IDLE;
                    last_d   = owner_q;
                end else if (cnt_q >= TO_LAST) begin
                    rd_valid    = 1'b1;
                    rd_resp     = RESP_SLVERR;
                    sts_timeout = 1'b1;
                    state_d     = IDLE;
                    last_d      = owner_q;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
        m0_readdatavalid = rd_valid & ~owner_q;
        m1_readdatavalid = rd_valid & owner_q;
        m0_readdata = m0_readdatavalid ? rd_data : '0;
        m1_readdata = m1_readdatavalid ? rd_data : '0;
        m0_response = m0_readdatavalid ? rd_resp : RESP_OKAY;
        m1_response = m1_readdatavalid ? rd_resp : RESP_OKAY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed checks of the two-host Avalon-MM arbiter.
module tb_avalon_mm_arbiter;
    import avalon_mm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  m0_addr, m1_addr, s_addr;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [1:0]  m0_response, m1_response;
    logic        s_read, s_write, s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic [1:0]  s_response;
    logic        sts_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    avalon_mm_arbiter #(.ADDR_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_response(m0_response),
        .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_response(m1_response),
        .s_addr(s_addr), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .s_response(s_response),
        .sts_timeout(sts_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_addr = '0; m0_read = 0; m0_write = 0;
        m0_writedata = '0; m0_byteenable = '0;
        m1_addr = '0; m1_read = 0; m1_write = 0;
        m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 0; s_readdata = '0;
        s_readdatavalid = 0; s_response = '0;

        // Reset behaviour
        tick();
        m0_read = 1; s_readdatavalid = 1;
        tick(); settle();
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_s_read", 32'(s_read), 0);
        chk("rst_m0_wait", 32'(m0_waitrequest), 1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 0);
        chk("rst_m0_rdv", 32'(m0_readdatavalid), 0);
        chk("rst_tmo", 32'(sts_timeout), 0);
        tick();
        rst_n = 1; m0_read = 0; s_readdatavalid = 0;

        // Single-host write
        tick();
        m0_write = 1; m0_addr = 4'h2;
        m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        settle();
        chk("wr_idle_s_write", 32'(s_write), 0);
        chk("wr_idle_wait", 32'(m0_waitrequest), 1);
        tick(); settle();
        chk("wr_s_write", 32'(s_write), 1);
        chk("wr_s_addr", 32'(s_addr), 32'h2);
        chk("wr_s_data", s_writedata, 32'hDEADBEEF);
        chk("wr_s_be", 32'(s_byteenable), 32'hF);
        chk("wr_wait", 32'(m0_waitrequest), 0);
        tick();
        m0_write = 0;
        settle();
        chk("wr_after", 32'(s_write), 0);

        // Simultaneous reads after reset
        tick(); rst_n = 0;
        tick(); rst_n = 1;
        tick();
        m0_read = 1; m0_addr = 4'h1;
        m1_read = 1; m1_addr = 4'h3;
        settle();
        chk("rd_idle_w0", 32'(m0_waitrequest), 1);
        chk("rd_idle_w1", 32'(m1_waitrequest), 1);
        tick(); settle();
        chk("rd0_s_read", 32'(s_read), 1);
        chk("rd0_s_addr", 32'(s_addr), 32'h1);
        chk("rd0_w0", 32'(m0_waitrequest), 0);
        chk("rd0_w1", 32'(m1_waitrequest), 1);
        tick();
        m0_read = 0;
        settle();
        chk("rd0_wait_s_read", 32'(s_read), 0);
        chk("rd0_wait_rdv", 32'(m0_readdatavalid), 0);
        tick();
        s_readdatavalid = 1; s_readdata = 32'h11111111;
        settle();
        chk("rd0_rdv", 32'(m0_readdatavalid), 1);
        chk("rd0_data", m0_readdata, 32'h11111111);
        chk("rd0_m1_rdv", 32'(m1_readdatavalid), 0);
        chk("rd0_m1_data", m1_readdata, 0);
        tick();
        s_readdatavalid = 0;
        settle();
        chk("rd1_idle_w1", 32'(m1_waitrequest), 1);
        tick(); settle();
        chk("rd1_s_read", 32'(s_read), 1);
        chk("rd1_s_addr", 32'(s_addr), 32'h3);
        chk("rd1_w1", 32'(m1_waitrequest), 0);
        tick();
        m1_read = 0;
        s_readdatavalid = 1; s_readdata = 32'h22222222;
        settle();
        chk("rd1_rdv", 32'(m1_readdatavalid), 1);
        chk("rd1_data", m1_readdata, 32'h22222222);
        chk("rd1_m0_rdv", 32'(m0_readdatavalid), 0);
        tick();
        s_readdatavalid = 0; s_readdata = '0;

        // Back-to-back contention
        m0_write = 1; m0_writedata = 32'hAAAA0000;
        m1_write = 1; m1_writedata = 32'hBBBB0000;
        for (int i = 0; i < 8; i++) begin
            tick(); settle();
            chk($sformatf("rr_%0d", i), s_writedata,
                (i % 2 == 0) ? 32'hAAAA0000 : 32'hBBBB0000);
            tick(); settle();
            chk($sformatf("rr_idle_%0d", i), 32'(s_write), 0);
        end
        m0_write = 0; m1_write = 0;

        // Read timeout
        tick();
        m1_read = 1; m1_addr = 4'h5;
        tick(); settle();
        chk("to_s_read", 32'(s_read), 1);
        tick();
        m1_read = 0;
        for (int k = 1; k < 8; k++) begin
            settle();
            chk($sformatf("to_wait_%0d", k),
                32'({sts_timeout, m1_readdatavalid}), 0);
            tick();
        end
        settle();
        chk("to_rdv", 32'(m1_readdatavalid), 1);
        chk("to_data", m1_readdata, 0);
        chk("to_resp", 32'(m1_response), 32'(RESP_SLVERR));
        chk("to_pulse", 32'(sts_timeout), 1);
        chk("to_m0_rdv", 32'(m0_readdatavalid), 0);
        tick();
        m0_write = 1; m0_writedata = 32'h0000C0DE;
        settle();
        chk("to_pulse_end", 32'(sts_timeout), 0);
        tick(); settle();
        chk("to_next_wr", 32'(s_write), 1);
        chk("to_next_data", s_writedata, 32'h0000C0DE);
        tick();
        m0_write = 0;

        // Valid arriving on the timeout cycle
        tick();
        m0_read = 1; m0_addr = 4'h7;
        tick();
        tick();
        m0_read = 0;
        for (int k = 1; k < 8; k++) tick();
        s_readdatavalid = 1; s_readdata = 32'hCAFEF00D;
        s_response = RESP_OKAY;
        settle();
        chk("col_rdv", 32'(m0_readdatavalid), 1);
        chk("col_data", m0_readdata, 32'hCAFEF00D);
        chk("col_resp", 32'(m0_response), 32'(RESP_OKAY));
        chk("col_tmo", 32'(sts_timeout), 0);
        tick();
        s_readdatavalid = 0; s_readdata = '0;

        // Reset while waiting for read data
        tick();
        m1_read = 1;
        tick();
        tick();
        m1_read = 0;
        tick();
        rst_n = 0;
        settle();
        chk("rmid_rst_rdv", 32'(m1_readdatavalid), 0);
        tick();
        rst_n = 1;
        s_readdatavalid = 1; s_readdata = 32'h12345678;
        settle();
        chk("rmid_m0_rdv", 32'(m0_readdatavalid), 0);
        chk("rmid_m1_rdv", 32'(m1_readdatavalid), 0);
        chk("rmid_m1_data", m1_readdata, 0);
        chk("rmid_state", 32'(dut.state_q), 32'(IDLE));
        tick();
        s_readdatavalid = 0;
        settle();
        chk("rmid_m1_rdv2", 32'(m1_readdatavalid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
